hamming_tx_serial: RTL

HAMMING_TX_SERIAL -- requirements
Module: hamming_tx_serial

---
 rtl/hamming_tx_if.sv | 22 ++
 rtl/hamming_tx_serial.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hamming_tx_if.sv
// Request/line bundle between a Hamming(8,4) serial transmitter and its user.
// The master drives the nibble and error position; the slave returns status and the line.
interface hamming_tx_if;
  logic [3:0] conmutador_4;
  logic [3:0] err_pos;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic [7:0] codeword;
  logic       busy;
  logic       done;

  modport master (
    output conmutador_4, err_pos, in_valid,
    input  in_ready, tx, codeword, busy, done
  );

  modport slave (
    input  conmutador_4, err_pos, in_valid,
    output in_ready, tx, codeword, busy, done
  );
endinterface

// File: rtl/hamming_tx_serial.sv
// Encodes a nibble as an extended Hamming(8,4) word, optionally flips one bit,
// and shifts it out LSB first as a start/8-data/stop frame on an idle-high line.
module hamming_tx_serial #(
  parameter int BIT_DIV = 234
) (
  input  logic         clk,
  input  logic         rst_n,
  hamming_tx_if.slave  bus
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(BIT_DIV - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic          tx_reg;
  logic          ready_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [7:0]    codeword_reg;

  logic [3:0] d;
  logic [6:0] ham;
  logic [7:0] enc;
  logic [7:0] flip_mask;
  logic [7:0] inj;

  assign d   = bus.conmutador_4;
  assign ham = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
                d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  assign enc = {^ham, ham};

  // err_pos values outside 1..8 match no mask bit, leaving the word untouched.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_flip
      assign flip_mask[gi] = (bus.err_pos == 4'(gi + 1));
    end
  endgenerate

  assign inj = enc ^ flip_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= 3'd0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      codeword_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (ready_reg && bus.in_valid) begin
            state_reg    <= START;
            codeword_reg <= inj;
            tx_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == LAST) begin
            state_reg   <= DATA;
            cnt_reg     <= '0;
            bit_idx_reg <= 3'd0;
            tx_reg      <= codeword_reg[0];
          end else begin
            cnt_reg <= cnt_reg + ONE;
          end
        end
        DATA: begin
          if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= codeword_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            cnt_reg <= cnt_reg + ONE;
          end
        end
        STOP: begin
          if (cnt_reg == LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            tx_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + ONE;
            // done is registered, so raise it one cycle ahead of the final stop cycle.
            done_reg <= (cnt_reg == PRE_LAST);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = tx_reg;
  assign bus.in_ready = ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.codeword = codeword_reg;

endmodule
